// File: rtl/ctrl_sched_pkg.sv
// Shared types, defaults and width helper for the control-word scheduler.
// Optional build macro CTRL_SCHED_FIXED_PRIO_EN is consumed by the arbiter and top.
package ctrl_sched_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } sched_state_e;

  localparam int unsigned DEF_NUM_REQ    = 32'd4;
  localparam int unsigned DEF_DATA_WIDTH = 32'd8;
  localparam int unsigned DEF_MIN_HOLD   = 32'd16;

  // Ceiling log2, never less than 1 so it can size a vector directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 32'd0;
    while ((32'd1 << width) < value) begin
      width = width + 32'd1;
    end
    return (width == 32'd0) ? 32'd1 : width;
  endfunction

endpackage

// File: rtl/ctrl_word_scheduler_rr_arbiter.sv
// Combinational grant selector: round-robin from a pointer, or fixed lowest-index
// priority when CTRL_SCHED_FIXED_PRIO_EN is defined (the pointer port disappears).
module rr_arbiter
  import ctrl_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef CTRL_SCHED_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  // First asserted request, scanning upward from the start index with wrap.
  always_comb begin : arb_p
    logic [IDX_W-1:0] idx_v;
    logic [IDX_W:0]   sum_v;
    logic             hit_v;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx_v     = '0;
    sum_v     = '0;
    hit_v     = 1'b0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
`ifdef CTRL_SCHED_FIXED_PRIO_EN
      sum_v = (IDX_W+1)'(k);
`else
      sum_v = {1'b0, ptr} + (IDX_W+1)'(k);
      sum_v = (sum_v >= (IDX_W+1)'(NUM_REQ)) ? (sum_v - (IDX_W+1)'(NUM_REQ)) : sum_v;
`endif
      idx_v            = sum_v[IDX_W-1:0];
      hit_v            = !grant_any && req[idx_v];
      grant[idx_v]     = grant[idx_v] | hit_v;
      grant_idx        = hit_v ? idx_v : grant_idx;
      grant_any        = grant_any | hit_v;
    end
  end

endmodule

// File: rtl/ctrl_word_scheduler.sv
// Shares one rate-limited control word among NUM_REQ requesters with a dwell of
// MIN_HOLD cycles after each change. Build macro: CTRL_SCHED_FIXED_PRIO_EN.
module ctrl_word_scheduler
  import ctrl_sched_pkg::*;
#(
  parameter int unsigned           NUM_REQ     = DEF_NUM_REQ,
  parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned           MIN_HOLD    = DEF_MIN_HOLD,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         ctrl_out,
  output logic                          ctrl_update,
  output logic [clog2(NUM_REQ)-1:0]     grant_id,
  output logic                          busy
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CNT_W = clog2(MIN_HOLD + 32'd1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(MIN_HOLD - 32'd1);

  sched_state_e            state_r;
  sched_state_e            state_nxt_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [DATA_WIDTH-1:0]   ctrl_out_r;
  logic                    ctrl_update_r;
  logic [IDX_W-1:0]        grant_id_r;
  logic [NUM_REQ-1:0]      grant_s;
  logic [IDX_W-1:0]        grant_idx_s;
  logic                    grant_any_s;
  logic [DATA_WIDTH-1:0]   sel_data_s;
  logic                    xfer_s;
  logic                    change_s;

`ifndef CTRL_SCHED_FIXED_PRIO_EN
  logic [IDX_W-1:0]        ptr_r;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req_valid),
`ifndef CTRL_SCHED_FIXED_PRIO_EN
    .ptr       (ptr_r),
`endif
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Word offered by the winning requester.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sel_data_s = (grant_idx_s == IDX_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
    end
  end

  assign xfer_s   = (state_r == IDLE) && grant_any_s;
  assign change_s = xfer_s && (sel_data_s != ctrl_out_r);

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: only a real change of the word starts a dwell.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = change_s ? HOLD : IDLE;
      HOLD:    state_nxt_s = (cnt_r == '0) ? IDLE : HOLD;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Accept strobe; forced low while reset is held so no handshake is seen.
  always_comb begin
    req_ready = '0;
    if (aresetn && (state_r == IDLE)) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Applied word, update pulse, grant id, dwell counter and rotation pointer.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      ctrl_out_r    <= RESET_VALUE;
      ctrl_update_r <= 1'b0;
      grant_id_r    <= '0;
      cnt_r         <= '0;
`ifndef CTRL_SCHED_FIXED_PRIO_EN
      ptr_r         <= '0;
`endif
    end else begin
      ctrl_update_r <= change_s;
      if (change_s) begin
        ctrl_out_r <= sel_data_s;
      end
      if (xfer_s) begin
        grant_id_r <= grant_idx_s;
`ifndef CTRL_SCHED_FIXED_PRIO_EN
        ptr_r      <= (grant_idx_s == IDX_W'(NUM_REQ - 32'd1)) ? '0 : (grant_idx_s + IDX_W'(1));
`endif
      end
      case (state_r)
        IDLE:    cnt_r <= change_s ? HOLD_LOAD : cnt_r;
        HOLD:    cnt_r <= (cnt_r != '0) ? (cnt_r - CNT_W'(1)) : cnt_r;
        default: cnt_r <= '0;
      endcase
    end
  end

  assign ctrl_out    = ctrl_out_r;
  assign ctrl_update = ctrl_update_r;
  assign grant_id    = grant_id_r;
  assign busy        = (state_r == HOLD);

endmodule

// File: tb/tb_ctrl_word_scheduler.sv
// Randomized + directed bench for ctrl_word_scheduler against a cycle-level reference model.
module tb_ctrl_word_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   ctrl_out;
  logic           ctrl_update;
  logic [1:0]     grant_id;
  logic           busy;

  ctrl_word_scheduler #(
    .NUM_REQ     (N),
    .DATA_WIDTH  (W),
    .MIN_HOLD    (MH),
    .RESET_VALUE (8'h00)
  ) dut (
    .clk         (clk),
    .aresetn     (aresetn),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .ctrl_out    (ctrl_out),
    .ctrl_update (ctrl_update),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: applied word, rotation start, last grant, remaining dwell cycles.
  logic [W-1:0] m_ctrl = 8'h00;
  int           m_ptr = 0;
  int           m_gid = 0;
  int           m_hold = 0;
  logic         m_upd = 1'b0;
  int           last_g = -1;
  int           cyc = 0;
  int           last_upd = -1;
  int           order[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    if (m_hold == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
`ifdef CTRL_SCHED_FIXED_PRIO_EN
        idx = k;
`else
        idx = (m_ptr + k) % N;
`endif
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    return g;
  endfunction

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic step();
    int           g;
    logic [N-1:0] er;
    logic [W-1:0] d;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check_eq("req_ready", req_ready, er);
    check_eq("ctrl_out", ctrl_out, m_ctrl);
    check_eq("ctrl_update", ctrl_update, m_upd);
    check_eq("grant_id", grant_id, m_gid);
    check_eq("busy", busy, m_hold > 0);
    if (ctrl_update === 1'b1) begin
      if (last_upd >= 0) check_eq("update_gap", (cyc - last_upd) >= (MH + 1), 1'b1);
      last_upd = cyc;
    end
    m_upd = 1'b0;
    if (m_hold > 0) begin
      m_hold--;
    end else if (g >= 0) begin
      d     = req_data[g*W +: W];
      m_gid = g;
      m_ptr = (g + 1) % N;
      if (d != m_ctrl) begin
        m_ctrl = d;
        m_upd  = 1'b1;
        m_hold = MH;
      end
    end
    last_g = g;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 aresetn = 1'b0;
    #1;
    check_eq("rst_ctrl_out", ctrl_out, 8'h00);
    check_eq("rst_ctrl_update", ctrl_update, 1'b0);
    check_eq("rst_grant_id", grant_id, 2'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_req_ready", req_ready, 4'b0000);
    m_ctrl = 8'h00; m_ptr = 0; m_gid = 0; m_hold = 0; m_upd = 1'b0;
    last_g = -1; last_upd = -1;
    repeat (2) @(posedge clk);
    #3 aresetn = 1'b1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] d);
    req_valid[i]      = v;
    req_data[i*W +: W] = d;
  endtask

  // Requesters keep valid/data until accepted; occasionally drop or start a request.
  task automatic drive_random();
    for (int i = 0; i < N; i++) begin
      if (last_g == i) req_valid[i] = 1'b0;
      if (!req_valid[i]) begin
        if ($urandom_range(0, 2) == 0) set_req(i, 1'b1, 8'($urandom_range(0, 5)));
      end else if ($urandom_range(0, 15) == 0) begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  initial begin
    do_reset();

    // Single request applied one cycle after its handshake, then a dwell.
    set_req(0, 1'b1, 8'hA5);
    step();
    check_eq("t1_grant", last_g, 0);
    req_valid = '0;
    check_eq("t1_ctrl_out", ctrl_out, 8'hA5);
    check_eq("t1_update", ctrl_update, 1'b1);
    repeat (MH + 2) step();

    // Redundant word: accepted without an update, next requester served right after.
    set_req(2, 1'b1, 8'hA5);
    set_req(3, 1'b1, 8'h5A);
    step();
    check_eq("t3_grant", last_g, 2);
    req_valid[2] = 1'b0;
    check_eq("t3_no_update", ctrl_update, 1'b0);
    check_eq("t3_not_busy", busy, 1'b0);
    step();
    check_eq("t3_next_grant", last_g, 3);
    req_valid[3] = 1'b0;

    // Request raised during the dwell waits for the first idle cycle.
    set_req(1, 1'b1, 8'h66);
    repeat (MH + 2) begin
      step();
      if (last_g == 1) req_valid[1] = 1'b0;
    end

    // All four valid with distinct words from a fresh rotation.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 8'(8'h11 * (i + 1)));
    order.delete();
    repeat (4 * (MH + 1) + 2) begin
      step();
      if (last_g >= 0) begin
        order.push_back(last_g);
        req_valid[last_g] = 1'b0;
      end
    end
    check_eq("t2_count", order.size(), 4);
`ifndef CTRL_SCHED_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) check_eq("t2_order", order[k], k);
`endif

    // Reset mid-dwell with req1 pending; req1 wins first afterwards.
    set_req(0, 1'b1, 8'h3C);
    step();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 8'h7E);
    step();
    check_eq("t5_busy_before", busy, 1'b1);
    do_reset();
    step();
    check_eq("t5_first_grant", last_g, 1);
    req_valid[1] = 1'b0;
    repeat (MH + 1) step();

    // req0 and req2 held valid with fresh words after every acceptance.
    set_req(0, 1'b1, 8'h80);
    set_req(2, 1'b1, 8'hC0);
    repeat (30) begin
      step();
      if (last_g == 0) req_data[0 +: W] = req_data[0 +: W] + 8'd1;
      if (last_g == 2) req_data[2*W +: W] = req_data[2*W +: W] + 8'd1;
    end
    req_valid[0] = 1'b0;
    repeat (2 * (MH + 1)) begin
      step();
      if (last_g == 2) req_valid[2] = 1'b0;
    end

    // Random traffic with a small word alphabet so redundant words are common.
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      step();
      if (n == 700) begin
        do_reset();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
